conv_addr_gen: RTL and testbench

- Upstream feeder for the address register file stage of the convolution datapath.
- Sweeps a configured feature map (rows x cols x channels) in channel-fastest order.
- Each beat emits LANES packed row/col/ch address triples.
- Lanes past the channel extent carry the invalid-address pattern (field MSB=1, rest 0), so the downstream address pipeline and memories ignore them.

---
 rtl/espnet_addr_pkg.sv | 17 +
 rtl/addr_lane_pack.sv | 46 ++++
 rtl/conv_addr_gen.sv | 171 +++++++++++++++++
 tb/tb_conv_addr_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/espnet_addr_pkg.sv
// rtl/espnet_addr_pkg.sv - shared widths, invalid-address patterns and FSM encoding for the address feeder
package espnet_addr_pkg;

  localparam int ROW_W_DEF = 10;
  localparam int COL_W_DEF = 11;
  localparam int CH_W_DEF  = 8;

  // Field MSB set, rest zero: downstream address pipeline treats the lane as empty
  localparam logic [ROW_W_DEF-1:0] ROW_INV = 10'h200;
  localparam logic [COL_W_DEF-1:0] COL_INV = 11'h400;
  localparam logic [CH_W_DEF-1:0]  CH_INV  = 8'h80;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/addr_lane_pack.sv
// rtl/addr_lane_pack.sv - combinational packing of row/col/channel triples into LANES-wide buses
module addr_lane_pack
  import espnet_addr_pkg::*;
#(
  parameter int LANES = 256,
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic [ROW_W-1:0]       row,
  input  logic [COL_W-1:0]       col,
  input  logic [CH_W-1:0]        ch_base,
  input  logic [CH_W-1:0]        chs,
  output logic [LANES*ROW_W-1:0] row_bus,
  output logic [LANES*COL_W-1:0] col_bus,
  output logic [LANES*CH_W-1:0]  ch_bus
);

  // Wide enough that ch_base + lane index never wraps before the compare
  localparam int IW = CH_W + $clog2(LANES) + 1;
  localparam logic [ROW_W-1:0] ROW_FLAG = {1'b1, {(ROW_W-1){1'b0}}};
  localparam logic [COL_W-1:0] COL_FLAG = {1'b1, {(COL_W-1){1'b0}}};
  localparam logic [CH_W-1:0]  CH_FLAG  = {1'b1, {(CH_W-1){1'b0}}};

  logic [IW-1:0] ch_idx;

  always_comb begin
    row_bus = '0;
    col_bus = '0;
    ch_bus  = '0;
    ch_idx  = '0;
    for (int i = 0; i < LANES; i++) begin
      ch_idx = IW'(ch_base) + IW'(i);
      if (ch_idx < IW'(chs)) begin
        row_bus[i*ROW_W +: ROW_W] = row & ~ROW_FLAG;
        col_bus[i*COL_W +: COL_W] = col & ~COL_FLAG;
        ch_bus[i*CH_W +: CH_W]    = ch_idx[CH_W-1:0] & ~CH_FLAG;
      end else begin
        row_bus[i*ROW_W +: ROW_W] = ROW_FLAG;
        col_bus[i*COL_W +: COL_W] = COL_FLAG;
        ch_bus[i*CH_W +: CH_W]    = CH_FLAG;
      end
    end
  end

endmodule

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - feature-map address sweeper, channel-fastest; CONV_ADDR_GEN_STRIDE2_EN adds stride-2 row/col
module conv_addr_gen
  import espnet_addr_pkg::*;
#(
  parameter int LANES = 256,
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROW_W-1:0]       cfg_rows,
  input  logic [COL_W-1:0]       cfg_cols,
  input  logic [CH_W-1:0]        cfg_chs,
`ifdef CONV_ADDR_GEN_STRIDE2_EN
  input  logic                   cfg_stride2,
`endif
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES*ROW_W-1:0] row_out,
  output logic [LANES*COL_W-1:0] col_out,
  output logic [LANES*CH_W-1:0]  ch_out,
  output logic                   busy,
  output logic                   done
);

  // Legal maximum equals the invalid pattern value (2^(W-1))
  localparam logic [ROW_W-1:0] ROW_MAX = {1'b1, {(ROW_W-1){1'b0}}};
  localparam logic [COL_W-1:0] COL_MAX = {1'b1, {(COL_W-1){1'b0}}};
  localparam logic [CH_W-1:0]  CH_MAX  = {1'b1, {(CH_W-1){1'b0}}};

  logic [1:0]       state_q;
  logic [ROW_W-1:0] rows_q, row_q, rows_c, nxt_row, pk_row;
  logic [COL_W-1:0] cols_q, col_q, cols_c, nxt_col, pk_col;
  logic [CH_W-1:0]  chs_q, ch_q, chs_c, nxt_ch, pk_ch, pk_chs;
  logic [1:0]       step;
  logic [31:0]      ch_adv, col_adv, row_adv;
  logic             ch_wrap, col_wrap, row_end, last_beat, cfg_zero, accept;
  logic [LANES*ROW_W-1:0] pk_row_bus;
  logic [LANES*COL_W-1:0] pk_col_bus;
  logic [LANES*CH_W-1:0]  pk_ch_bus;

`ifdef CONV_ADDR_GEN_STRIDE2_EN
  logic stride2_q;
  assign step = stride2_q ? 2'd2 : 2'd1;
`else
  assign step = 2'd1;
`endif

  assign rows_c   = (cfg_rows > ROW_MAX) ? ROW_MAX : cfg_rows;
  assign cols_c   = (cfg_cols > COL_MAX) ? COL_MAX : cfg_cols;
  assign chs_c    = (cfg_chs > CH_MAX) ? CH_MAX : cfg_chs;
  assign cfg_zero = (rows_c == '0) || (cols_c == '0) || (chs_c == '0);

  assign ch_adv    = 32'(ch_q) + 32'(LANES);
  assign col_adv   = 32'(col_q) + 32'(step);
  assign row_adv   = 32'(row_q) + 32'(step);
  assign ch_wrap   = ch_adv >= 32'(chs_q);
  assign col_wrap  = col_adv >= 32'(cols_q);
  assign row_end   = row_adv >= 32'(rows_q);
  assign last_beat = ch_wrap && col_wrap && row_end;
  assign accept    = (state_q == ST_RUN) && out_valid && out_ready;

  always_comb begin
    nxt_ch  = ch_q;
    nxt_col = col_q;
    nxt_row = row_q;
    if (!ch_wrap) begin
      nxt_ch = ch_adv[CH_W-1:0];
    end else begin
      nxt_ch = '0;
      if (!col_wrap) begin
        nxt_col = col_adv[COL_W-1:0];
      end else begin
        nxt_col = '0;
        nxt_row = row_adv[ROW_W-1:0];
      end
    end
  end

  // In IDLE the packer sees beat 0 of the incoming config so it can be registered on start
  assign pk_row = (state_q == ST_IDLE) ? '0 : nxt_row;
  assign pk_col = (state_q == ST_IDLE) ? '0 : nxt_col;
  assign pk_ch  = (state_q == ST_IDLE) ? '0 : nxt_ch;
  assign pk_chs = (state_q == ST_IDLE) ? chs_c : chs_q;

  addr_lane_pack #(
    .LANES (LANES),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .CH_W  (CH_W)
  ) u_pack (
    .row     (pk_row),
    .col     (pk_col),
    .ch_base (pk_ch),
    .chs     (pk_chs),
    .row_bus (pk_row_bus),
    .col_bus (pk_col_bus),
    .ch_bus  (pk_ch_bus)
  );

  assign busy = (state_q == ST_RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      chs_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
`ifdef CONV_ADDR_GEN_STRIDE2_EN
      stride2_q <= 1'b0;
`endif
      out_valid <= 1'b0;
      done      <= 1'b0;
      row_out   <= {LANES{ROW_MAX}};
      col_out   <= {LANES{COL_MAX}};
      ch_out    <= {LANES{CH_MAX}};
    end else begin
      done <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_q <= rows_c;
            cols_q <= cols_c;
            chs_q  <= chs_c;
`ifdef CONV_ADDR_GEN_STRIDE2_EN
            stride2_q <= cfg_stride2;
`endif
            row_q  <= '0;
            col_q  <= '0;
            ch_q   <= '0;
            if (cfg_zero) begin
              state_q <= ST_DONE;
            end else begin
              state_q   <= ST_RUN;
              out_valid <= 1'b1;
              row_out   <= pk_row_bus;
              col_out   <= pk_col_bus;
              ch_out    <= pk_ch_bus;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_beat) begin
              state_q   <= ST_DONE;
              out_valid <= 1'b0;
              row_out   <= {LANES{ROW_MAX}};
              col_out   <= {LANES{COL_MAX}};
              ch_out    <= {LANES{CH_MAX}};
            end else begin
              row_q   <= nxt_row;
              col_q   <= nxt_col;
              ch_q    <= nxt_ch;
              row_out <= pk_row_bus;
              col_out <= pk_col_bus;
              ch_out  <= pk_ch_bus;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb/tb_conv_addr_gen.sv - directed-vector bench for conv_addr_gen (LANES=256 and LANES=4 instances)
module tb_conv_addr_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start = 1'b0;
  logic [9:0]    cfg_rows = '0;
  logic [10:0]   cfg_cols = '0;
  logic [7:0]    cfg_chs = '0;
  logic          out_ready = 1'b1;
  logic          out_valid, busy, done;
  logic [2559:0] row_out;
  logic [2815:0] col_out;
  logic [2047:0] ch_out;
`ifdef CONV_ADDR_GEN_STRIDE2_EN
  logic          cfg_stride2 = 1'b0;
`endif

  logic          s_start = 1'b0;
  logic [9:0]    s_cfg_rows = '0;
  logic [10:0]   s_cfg_cols = '0;
  logic [7:0]    s_cfg_chs = '0;
  logic          s_out_ready = 1'b1;
  logic          s_out_valid, s_busy, s_done;
  logic [39:0]   s_row_out;
  logic [43:0]   s_col_out;
  logic [31:0]   s_ch_out;
`ifdef CONV_ADDR_GEN_STRIDE2_EN
  logic          s_cfg_stride2 = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  conv_addr_gen #(.LANES(256)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cfg_rows    (cfg_rows),
    .cfg_cols    (cfg_cols),
    .cfg_chs     (cfg_chs),
`ifdef CONV_ADDR_GEN_STRIDE2_EN
    .cfg_stride2 (cfg_stride2),
`endif
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .row_out     (row_out),
    .col_out     (col_out),
    .ch_out      (ch_out),
    .busy        (busy),
    .done        (done)
  );

  conv_addr_gen #(.LANES(4)) u_dut4 (
    .clock       (clock),
    .reset       (reset),
    .start       (s_start),
    .cfg_rows    (s_cfg_rows),
    .cfg_cols    (s_cfg_cols),
    .cfg_chs     (s_cfg_chs),
`ifdef CONV_ADDR_GEN_STRIDE2_EN
    .cfg_stride2 (s_cfg_stride2),
`endif
    .out_ready   (s_out_ready),
    .out_valid   (s_out_valid),
    .row_out     (s_row_out),
    .col_out     (s_col_out),
    .ch_out      (s_ch_out),
    .busy        (s_busy),
    .done        (s_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_inv();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (row_out[i*10 +: 10] == 10'h200 && col_out[i*11 +: 11] == 11'h400 && ch_out[i*8 +: 8] == 8'h80)
        n++;
    return n;
  endfunction

  // Beat of the rows=2 cols=3 chs=4 sweep: lanes 0..3 valid, 252 lanes invalid
  task automatic check_beat(input string tag, input int r, input int c);
    logic [9:0]  r10;
    logic [10:0] c11;
    r10 = r[9:0];
    c11 = c[10:0];
    check($sformatf("%s_valid", tag), out_valid, 1'b1);
    check($sformatf("%s_busy", tag), busy, 1'b1);
    check($sformatf("%s_row", tag), row_out[39:0], {r10, r10, r10, r10});
    check($sformatf("%s_col", tag), col_out[43:0], {c11, c11, c11, c11});
    check($sformatf("%s_ch", tag), ch_out[31:0], 32'h03020100);
    check($sformatf("%s_inv", tag), count_inv(), 252);
  endtask

  task automatic run_sweep(input int stall_beat, input int stall_cycles);
    @(negedge clock);
    cfg_rows = 10'd2; cfg_cols = 11'd3; cfg_chs = 8'd4; out_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cfg_rows = 10'd0; cfg_cols = 11'd7; cfg_chs = 8'd1;
    for (int k = 0; k < 6; k++) begin
      check_beat($sformatf("beat%0d", k), k / 3, k % 3);
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clock);
          check_beat($sformatf("stall%0d", s), k / 3, k % 3);
        end
        out_ready = 1'b1;
      end
      @(negedge clock);
    end
    check("end_valid", out_valid, 1'b0);
    check("end_done_early", done, 1'b0);
    check("end_busy", busy, 1'b0);
    @(negedge clock);
    check("done_pulse", done, 1'b1);
    check("done_valid", out_valid, 1'b0);
    @(negedge clock);
    check("done_clear", done, 1'b0);
    check("idle_inv", count_inv(), 256);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_inv", count_inv(), 256);
    check("rst_s_ch", s_ch_out, 32'h80808080);
    check("rst_s_row", s_row_out, {4{10'h200}});
    reset = 1'b0;

    run_sweep(-1, 0);
    run_sweep(2, 5);

    // LANES=4: a 6-channel map takes two channel blocks
    @(negedge clock);
    s_cfg_rows = 10'd1; s_cfg_cols = 11'd1; s_cfg_chs = 8'd6; s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    check("l4_b0_valid", s_out_valid, 1'b1);
    check("l4_b0_ch", s_ch_out, 32'h03020100);
    check("l4_b0_row", s_row_out, 40'h0);
    @(negedge clock);
    check("l4_b1_valid", s_out_valid, 1'b1);
    check("l4_b1_ch", s_ch_out, 32'h80800504);
    check("l4_b1_row", s_row_out, {10'h200, 10'h200, 10'h000, 10'h000});
    check("l4_b1_col", s_col_out, {11'h400, 11'h400, 11'h000, 11'h000});
    @(negedge clock);
    check("l4_end_valid", s_out_valid, 1'b0);
    @(negedge clock);
    check("l4_done", s_done, 1'b1);

    // Zero-size config: no beats, done only
    @(negedge clock);
    cfg_rows = 10'd2; cfg_cols = 11'd0; cfg_chs = 8'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("z_valid1", out_valid, 1'b0);
    check("z_busy1", busy, 1'b0);
    check("z_done1", done, 1'b0);
    @(negedge clock);
    check("z_done2", done, 1'b1);
    check("z_valid2", out_valid, 1'b0);
    check("z_busy2", busy, 1'b0);
    @(negedge clock);
    check("z_done3", done, 1'b0);

    // Channel count above legal max clamps to 128
    @(negedge clock);
    cfg_rows = 10'd1; cfg_cols = 11'd1; cfg_chs = 8'hFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("cl_valid", out_valid, 1'b1);
    check("cl_lane127", ch_out[127*8 +: 8], 8'h7F);
    check("cl_lane128", ch_out[128*8 +: 8], 8'h80);
    check("cl_inv", count_inv(), 128);
    @(negedge clock);
    check("cl_end", out_valid, 1'b0);
    @(negedge clock);
    check("cl_done", done, 1'b1);

    // Asynchronous reset while beat 3 is presented
    @(negedge clock);
    cfg_rows = 10'd2; cfg_cols = 11'd3; cfg_chs = 8'd4; out_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_beat("pre_rst_beat3", 1, 0);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_inv", count_inv(), 256);
    @(negedge clock);
    reset = 1'b0;
    run_sweep(-1, 0);

`ifdef CONV_ADDR_GEN_STRIDE2_EN
    @(negedge clock);
    cfg_rows = 10'd4; cfg_cols = 11'd4; cfg_chs = 8'd1; cfg_stride2 = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s2_b%0d_valid", k), out_valid, 1'b1);
      check($sformatf("s2_b%0d_row", k), row_out[9:0], 10'((k / 2) * 2));
      check($sformatf("s2_b%0d_col", k), col_out[10:0], 11'((k % 2) * 2));
      check($sformatf("s2_b%0d_ch", k), ch_out[15:0], 16'h8000);
      @(negedge clock);
    end
    check("s2_end", out_valid, 1'b0);
    @(negedge clock);
    check("s2_done", done, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
